// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the fetch/data memory arbiter: FSM states, owner codes, funct3 constants.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2,
    ARB_DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_OWN_FETCH = 1'b0,
    ARB_OWN_DATA  = 1'b1
  } arb_owner_t;

  localparam logic [2:0] FUNCT3_WORD  = 3'b010;
  localparam int         STARVE_CNT_W = 4;

  // Stores are never abandoned once issued; fetches and loads may be.
  function automatic logic arb_flushable(input arb_owner_t owner, input logic store);
    return (owner == ARB_OWN_FETCH) || !store;
  endfunction

endpackage

// File: rtl/mem_arbiter_starve_cnt.sv
// Saturating count of data grants made while a fetch waits; limit flags that fetch must win next.
// Count updates only when rdy_in is high; clr has priority over inc.
module arb_starve_cnt
  import mem_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic rdy_in,
  input  logic inc,
  input  logic clr,
  output logic limit
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(LIMIT);

  logic [STARVE_CNT_W-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (rdy_in) begin
      if (clr) begin
        cnt <= '0;
      end else if (inc && (cnt < LIMIT_C)) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign limit = (cnt >= LIMIT_C);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory controller arbiter between instruction fetch and the LSB; grant->mc request 1 cycle, mc done->requester done 1 cycle.
// Holds the request until the controller reports busy (stalls on io_buffer_full_in); MEM_ARB_STARVE_EN adds the fetch starvation bound.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear_in,
  input  logic        io_buffer_full_in,
  input  logic        ic_req_in,
  input  logic [31:0] ic_addr_in,
  output logic        ic_done_out,
  output logic [31:0] ic_data_out,
  input  logic        lsb_req_in,
  input  logic        lsb_store_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [31:0] lsb_data_in,
  input  logic [2:0]  lsb_op_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_data_out,
  output logic        mc_fetch_out,
  output logic        mc_io_out,
  output logic        mc_store_out,
  output logic [31:0] mc_addr_out,
  output logic [31:0] mc_fetch_addr_out,
  output logic [31:0] mc_data_out,
  output logic [2:0]  mc_op_out,
  input  logic        mc_working_in,
  input  logic        mc_ins_done_in,
  input  logic [31:0] mc_ins_in,
  input  logic        mc_res_done_in,
  input  logic [31:0] mc_res_in
);

  arb_state_t state;
  arb_owner_t owner;

  logic starved;
  logic idle_ok;
  logic grant_data;
  logic grant_fetch;
  logic accepted;
  logic owner_done;
  logic kill;

  // No grant during a done pulse: the finishing requester still holds req that cycle.
  assign idle_ok     = (state == ARB_IDLE) && !clear_in && !ic_done_out && !lsb_done_out;
  assign grant_data  = idle_ok && lsb_req_in && !(starved && ic_req_in);
  assign grant_fetch = idle_ok && !grant_data && ic_req_in;

  assign accepted    = mc_working_in && !io_buffer_full_in;
  assign owner_done  = (owner == ARB_OWN_FETCH) ? mc_ins_done_in : mc_res_done_in;
  assign kill        = clear_in && arb_flushable(owner, mc_store_out);

  assign mc_fetch_addr_out = mc_addr_out;

`ifdef MEM_ARB_STARVE_EN
  logic starve_inc;
  logic starve_clr;

  assign starve_inc = grant_data && ic_req_in;
  assign starve_clr = grant_fetch || !ic_req_in;

  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_cnt (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .rdy_in(rdy_in),
    .inc   (starve_inc),
    .clr   (starve_clr),
    .limit (starved)
  );
`else
  // Fixed LSB priority; the limit only takes effect with the counter built.
  if (STARVE_LIMIT >= 0) begin : g_fixed_prio
    assign starved = 1'b0;
  end
`endif

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state        <= ARB_IDLE;
      owner        <= ARB_OWN_FETCH;
      ic_done_out  <= 1'b0;
      ic_data_out  <= '0;
      lsb_done_out <= 1'b0;
      lsb_data_out <= '0;
      mc_fetch_out <= 1'b0;
      mc_io_out    <= 1'b0;
      mc_store_out <= 1'b0;
      mc_addr_out  <= '0;
      mc_data_out  <= '0;
      mc_op_out    <= '0;
    end else if (rdy_in) begin
      ic_done_out  <= 1'b0;
      lsb_done_out <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (grant_data) begin
            owner        <= ARB_OWN_DATA;
            mc_io_out    <= 1'b1;
            mc_store_out <= lsb_store_in;
            mc_addr_out  <= lsb_addr_in;
            mc_data_out  <= lsb_data_in;
            mc_op_out    <= lsb_op_in;
            state        <= ARB_ISSUE;
          end else if (grant_fetch) begin
            owner        <= ARB_OWN_FETCH;
            mc_fetch_out <= 1'b1;
            mc_store_out <= 1'b0;
            mc_addr_out  <= ic_addr_in;
            mc_data_out  <= '0;
            mc_op_out    <= FUNCT3_WORD;
            state        <= ARB_ISSUE;
          end
        end
        ARB_ISSUE: begin
          if (accepted) begin
            mc_io_out    <= 1'b0;
            mc_fetch_out <= 1'b0;
          end
          // A killed command stays requested until the controller takes it, then drains.
          if (kill) begin
            state <= ARB_DRAIN;
          end else if (accepted) begin
            state <= ARB_WAIT;
          end
        end
        ARB_WAIT: begin
          if (kill) begin
            state <= owner_done ? ARB_IDLE : ARB_DRAIN;
          end else if (owner_done) begin
            state <= ARB_IDLE;
            if (owner == ARB_OWN_FETCH) begin
              ic_done_out <= 1'b1;
              ic_data_out <= mc_ins_in;
            end else begin
              lsb_done_out <= 1'b1;
              lsb_data_out <= mc_store_out ? '0 : mc_res_in;
            end
          end
        end
        ARB_DRAIN: begin
          if (accepted) begin
            mc_io_out    <= 1'b0;
            mc_fetch_out <= 1'b0;
          end
          if (owner_done) begin
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven solo transactions plus contention, starvation, flush, backpressure, ready and reset sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clear_in;
  logic        io_buffer_full_in;
  logic        ic_req_in;
  logic [31:0] ic_addr_in;
  logic        ic_done_out;
  logic [31:0] ic_data_out;
  logic        lsb_req_in;
  logic        lsb_store_in;
  logic [31:0] lsb_addr_in;
  logic [31:0] lsb_data_in;
  logic [2:0]  lsb_op_in;
  logic        lsb_done_out;
  logic [31:0] lsb_data_out;
  logic        mc_fetch_out;
  logic        mc_io_out;
  logic        mc_store_out;
  logic [31:0] mc_addr_out;
  logic [31:0] mc_fetch_addr_out;
  logic [31:0] mc_data_out;
  logic [2:0]  mc_op_out;
  logic        mc_working_in;
  logic        mc_ins_done_in;
  logic [31:0] mc_ins_in;
  logic        mc_res_done_in;
  logic [31:0] mc_res_in;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clear_in(clear_in),
    .io_buffer_full_in(io_buffer_full_in),
    .ic_req_in(ic_req_in), .ic_addr_in(ic_addr_in),
    .ic_done_out(ic_done_out), .ic_data_out(ic_data_out),
    .lsb_req_in(lsb_req_in), .lsb_store_in(lsb_store_in), .lsb_addr_in(lsb_addr_in),
    .lsb_data_in(lsb_data_in), .lsb_op_in(lsb_op_in),
    .lsb_done_out(lsb_done_out), .lsb_data_out(lsb_data_out),
    .mc_fetch_out(mc_fetch_out), .mc_io_out(mc_io_out), .mc_store_out(mc_store_out),
    .mc_addr_out(mc_addr_out), .mc_fetch_addr_out(mc_fetch_addr_out),
    .mc_data_out(mc_data_out), .mc_op_out(mc_op_out),
    .mc_working_in(mc_working_in), .mc_ins_done_in(mc_ins_done_in), .mc_ins_in(mc_ins_in),
    .mc_res_done_in(mc_res_done_in), .mc_res_in(mc_res_in)
  );

  always #5 clk_in = ~clk_in;

  int npass = 0;
  int nchk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  function automatic logic [31:0] resp_of(input logic [31:0] a);
    if (a == 32'h100) return 32'h00A00093;
    return {~a[15:0], a[15:0]};
  endfunction

  typedef struct {
    logic        f;
    logic        st;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  op;
  } cmd_t;

  typedef struct {
    logic        f;
    logic [31:0] data;
  } resp_t;

  cmd_t  cmd_q[$];
  resp_t resp_q[$];

  task automatic expect_txn(input logic f, input logic st, input logic [31:0] a,
                            input logic [31:0] d, input logic [2:0] op, input logic [31:0] rd);
    cmd_t  c;
    resp_t r;
    c.f = f; c.st = st; c.a = a; c.d = d; c.op = op;
    r.f = f; r.data = rd;
    cmd_q.push_back(c);
    resp_q.push_back(r);
  endtask

  // Memory controller model: accepts a request when idle and the UART buffer has room.
  int          ctl_lat = 2;
  int          ctl_cnt;
  logic        ctl_busy;
  logic        ctl_fetch;
  logic [31:0] ctl_addr;

  always @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      ctl_busy <= 1'b0; ctl_fetch <= 1'b0; ctl_addr <= '0; ctl_cnt <= 0;
      mc_working_in <= 1'b0; mc_ins_done_in <= 1'b0; mc_res_done_in <= 1'b0;
      mc_ins_in <= '0; mc_res_in <= '0;
    end else if (rdy_in) begin
      mc_ins_done_in <= 1'b0;
      mc_res_done_in <= 1'b0;
      if (!ctl_busy) begin
        if ((mc_fetch_out || mc_io_out) && !io_buffer_full_in) begin
          ctl_busy <= 1'b1; mc_working_in <= 1'b1;
          ctl_fetch <= mc_fetch_out; ctl_addr <= mc_addr_out; ctl_cnt <= ctl_lat;
        end
      end else if (ctl_cnt == 0) begin
        ctl_busy <= 1'b0; mc_working_in <= 1'b0;
        if (ctl_fetch) begin mc_ins_done_in <= 1'b1; mc_ins_in <= resp_of(ctl_addr); end
        else begin mc_res_done_in <= 1'b1; mc_res_in <= resp_of(ctl_addr); end
      end else begin
        ctl_cnt <= ctl_cnt - 1;
      end
    end
  end

  // Scoreboard: compare commands when the controller takes them, results when done pulses.
  always @(negedge clk_in) begin
    if (rst_in && rdy_in) begin
      if (!ctl_busy && (mc_fetch_out || mc_io_out) && !io_buffer_full_in) begin
        chk("cmd_expected", cmd_q.size() != 0, 1'b1);
        if (cmd_q.size() != 0) begin
          cmd_t e;
          e = cmd_q.pop_front();
          chk("cmd_fetch", mc_fetch_out, e.f);
          chk("cmd_io", mc_io_out, !e.f);
          chk("cmd_addr", mc_addr_out, e.a);
          chk("cmd_fetch_addr", mc_fetch_addr_out, e.a);
          chk("cmd_op", mc_op_out, e.op);
          if (!e.f) chk("cmd_store", mc_store_out, e.st);
          if (!e.f && e.st) chk("cmd_data", mc_data_out, e.d);
        end
      end
      if (ic_done_out || lsb_done_out) begin
        chk("done_expected", resp_q.size() != 0, 1'b1);
        chk("done_single", ic_done_out & lsb_done_out, 1'b0);
        if (resp_q.size() != 0) begin
          resp_t r;
          r = resp_q.pop_front();
          chk("done_owner", ic_done_out, r.f);
          chk("done_data", r.f ? ic_data_out : lsb_data_out, r.data);
        end
      end
    end
  end

  task automatic do_req(input logic f, input logic st, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] op, output int cyc);
    bit got;
    got = 1'b0;
    cyc = 0;
    @(posedge clk_in); #1;
    if (f) begin
      ic_req_in = 1'b1; ic_addr_in = a;
    end else begin
      lsb_req_in = 1'b1; lsb_store_in = st; lsb_addr_in = a; lsb_data_in = d; lsb_op_in = op;
    end
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_in);
      cyc++;
      if (rdy_in && (f ? ic_done_out : lsb_done_out)) got = 1'b1;
    end
    chk(f ? "fetch_done_seen" : "lsb_done_seen", got, 1'b1);
    @(posedge clk_in); #1;
    if (f) ic_req_in = 1'b0;
    else lsb_req_in = 1'b0;
  endtask

  task automatic req_lsb_stream(input int n, input logic [31:0] base);
    bit got;
    @(posedge clk_in); #1;
    lsb_req_in = 1'b1; lsb_store_in = 1'b0; lsb_op_in = 3'b010; lsb_addr_in = base;
    for (int k = 0; k < n; k++) begin
      got = 1'b0;
      for (int i = 0; i < 100 && !got; i++) begin
        @(negedge clk_in);
        if (rdy_in && lsb_done_out) got = 1'b1;
      end
      chk("stream_done_seen", got, 1'b1);
      @(posedge clk_in); #1;
      lsb_addr_in = base + 32'(4 * (k + 1));
    end
    lsb_req_in = 1'b0;
  endtask

  task automatic wait_wait_state(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk_in);
      if (mc_working_in && !mc_fetch_out && !mc_io_out) ok = 1'b1;
    end
  endtask

  typedef struct {
    logic        f;
    logic        st;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  op;
    logic [2:0]  exp_op;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int  cyc;
    int  base_cyc;
    bit  ok;
    bit  got;
    bit  early;
    bit  seen_ins;
    bit  ic_seen;
    int  held;

    vecs[0] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,         3'b111, 3'b010, 32'h00A0_0093};
    vecs[1] = '{1'b0, 1'b0, 32'h0000_2000, 32'h0,         3'b010, 3'b010, 32'hDFFF_2000};
    vecs[2] = '{1'b0, 1'b1, 32'h0000_3004, 32'hCAFE_BABE, 3'b000, 3'b000, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,         3'b101, 3'b101, 32'hFFBB_0044};
    vecs[4] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         3'b000, 3'b010, 32'hFDFF_0200};
    vecs[5] = '{1'b0, 1'b1, 32'h0003_0000, 32'h0000_0041, 3'b000, 3'b000, 32'h0};

    rst_in = 1'b0; rdy_in = 1'b1; clear_in = 1'b0; io_buffer_full_in = 1'b0;
    ic_req_in = 1'b0; ic_addr_in = '0;
    lsb_req_in = 1'b0; lsb_store_in = 1'b0; lsb_addr_in = '0; lsb_data_in = '0; lsb_op_in = '0;

    #12;
    chk("reset_mc_req", {mc_fetch_out, mc_io_out, mc_store_out}, 3'b000);
    chk("reset_mc_addr", mc_addr_out, 32'h0);
    chk("reset_done", {ic_done_out, lsb_done_out}, 2'b00);
    @(posedge clk_in); #1 rst_in = 1'b1;

    // Solo transactions from the table.
    for (int i = 0; i < 6; i++) begin
      lsb_op_in = vecs[i].op;
      expect_txn(vecs[i].f, vecs[i].st, vecs[i].a, vecs[i].d, vecs[i].exp_op, vecs[i].exp_data);
      do_req(vecs[i].f, vecs[i].st, vecs[i].a, vecs[i].d, vecs[i].op, cyc);
    end

    // Contention: load wins, fetch follows.
    expect_txn(1'b0, 1'b0, 32'h2000, 32'h0, 3'b010, resp_of(32'h2000));
    expect_txn(1'b1, 1'b0, 32'h104, 32'h0, 3'b010, resp_of(32'h104));
    fork
      do_req(1'b1, 1'b0, 32'h104, 32'h0, 3'b000, cyc);
      do_req(1'b0, 1'b0, 32'h2000, 32'h0, 3'b010, base_cyc);
    join

    // Starvation: continuous LSB loads while a fetch waits.
    ctl_lat = 1;
`ifdef MEM_ARB_STARVE_EN
    for (int i = 0; i < 4; i++)
      expect_txn(1'b0, 1'b0, 32'h4000 + 32'(4 * i), 32'h0, 3'b010, resp_of(32'h4000 + 32'(4 * i)));
    expect_txn(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, resp_of(32'h400));
    for (int i = 4; i < 6; i++)
      expect_txn(1'b0, 1'b0, 32'h4000 + 32'(4 * i), 32'h0, 3'b010, resp_of(32'h4000 + 32'(4 * i)));
`else
    for (int i = 0; i < 6; i++)
      expect_txn(1'b0, 1'b0, 32'h4000 + 32'(4 * i), 32'h0, 3'b010, resp_of(32'h4000 + 32'(4 * i)));
    expect_txn(1'b1, 1'b0, 32'h400, 32'h0, 3'b010, resp_of(32'h400));
`endif
    fork
      req_lsb_stream(6, 32'h4000);
      do_req(1'b1, 1'b0, 32'h400, 32'h0, 3'b000, cyc);
    join

    // Flush a fetch in WAIT: no done, next grant only after the controller finishes.
    ctl_lat = 6;
    begin
      cmd_t c;
      c.f = 1'b1; c.st = 1'b0; c.a = 32'h300; c.d = 32'h0; c.op = 3'b010;
      cmd_q.push_back(c);
    end
    @(posedge clk_in); #1 ic_req_in = 1'b1; ic_addr_in = 32'h300;
    wait_wait_state(ok);
    chk("flush_fetch_wait_reached", ok, 1'b1);
    @(posedge clk_in); #1 clear_in = 1'b1; ic_req_in = 1'b0;
    @(posedge clk_in); #1 clear_in = 1'b0;
    expect_txn(1'b0, 1'b0, 32'h2100, 32'h0, 3'b010, resp_of(32'h2100));
    lsb_req_in = 1'b1; lsb_store_in = 1'b0; lsb_addr_in = 32'h2100; lsb_op_in = 3'b010;
    got = 1'b0; early = 1'b0; seen_ins = 1'b0; ic_seen = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk_in);
      if (mc_io_out && !seen_ins) early = 1'b1;
      if (mc_ins_done_in) seen_ins = 1'b1;
      if (ic_done_out) ic_seen = 1'b1;
      if (lsb_done_out) got = 1'b1;
    end
    chk("drain_no_early_issue", early, 1'b0);
    chk("drain_ins_done_seen", seen_ins, 1'b1);
    chk("flush_no_ic_done", ic_seen, 1'b0);
    chk("after_drain_load_done", got, 1'b1);
    @(posedge clk_in); #1 lsb_req_in = 1'b0;

    // A store in WAIT survives a flush.
    expect_txn(1'b0, 1'b1, 32'h3008, 32'h1234, 3'b010, 32'h0);
    fork
      do_req(1'b0, 1'b1, 32'h3008, 32'h1234, 3'b010, cyc);
      begin
        bit sok;
        wait_wait_state(sok);
        chk("flush_store_wait_reached", sok, 1'b1);
        @(posedge clk_in); #1 clear_in = 1'b1;
        @(posedge clk_in); #1 clear_in = 1'b0;
      end
    join

    // UART backpressure holds the store request.
    ctl_lat = 2;
    io_buffer_full_in = 1'b1;
    expect_txn(1'b0, 1'b1, 32'h30000, 32'h55, 3'b010, 32'h0);
    fork
      do_req(1'b0, 1'b1, 32'h30000, 32'h55, 3'b010, cyc);
      begin
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk_in);
          if (mc_io_out) seen = 1'b1;
        end
        held = seen ? 1 : 0;
        for (int i = 0; i < 4; i++) begin
          @(negedge clk_in);
          if (mc_io_out) held++;
        end
        chk("bp_held_cycles", held, 5);
        @(posedge clk_in); #1 io_buffer_full_in = 1'b0;
        @(negedge clk_in);
        chk("bp_pending_on_release", mc_io_out, 1'b1);
      end
    join

    // rdy_in low in WAIT delays done by the stall length.
    ctl_lat = 4;
    expect_txn(1'b0, 1'b0, 32'h2400, 32'h0, 3'b010, resp_of(32'h2400));
    do_req(1'b0, 1'b0, 32'h2400, 32'h0, 3'b010, base_cyc);
    expect_txn(1'b0, 1'b0, 32'h2400, 32'h0, 3'b010, resp_of(32'h2400));
    fork
      do_req(1'b0, 1'b0, 32'h2400, 32'h0, 3'b010, cyc);
      begin
        bit rok;
        wait_wait_state(rok);
        chk("rdy_wait_reached", rok, 1'b1);
        @(posedge clk_in); #1 rdy_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 rdy_in = 1'b1;
      end
    join
    chk("rdy_stall_delay", cyc, base_cyc + 3);

    // Asynchronous reset in WAIT clears outputs without a clock edge.
    ctl_lat = 8;
    begin
      cmd_t c;
      c.f = 1'b0; c.st = 1'b0; c.a = 32'h2800; c.d = 32'h0; c.op = 3'b010;
      cmd_q.push_back(c);
    end
    @(posedge clk_in); #1;
    lsb_req_in = 1'b1; lsb_store_in = 1'b0; lsb_addr_in = 32'h2800; lsb_op_in = 3'b010;
    wait_wait_state(ok);
    chk("reset_wait_reached", ok, 1'b1);
    #1 rst_in = 1'b0;
    #1;
    chk("arst_mc_addr", mc_addr_out, 32'h0);
    chk("arst_mc_fetch_addr", mc_fetch_addr_out, 32'h0);
    chk("arst_ctrl_bits", {mc_fetch_out, mc_io_out, mc_store_out, mc_op_out, ic_done_out, lsb_done_out}, 8'h00);
    chk("arst_lsb_data", lsb_data_out, 32'h0);
    chk("arst_ic_data", ic_data_out, 32'h0);
    lsb_req_in = 1'b0;
    cmd_q.delete();
    resp_q.delete();
    @(posedge clk_in); #1 rst_in = 1'b1;
    @(negedge clk_in);
    chk("post_reset_no_req", {mc_fetch_out, mc_io_out}, 2'b00);
    ctl_lat = 2;
    expect_txn(1'b1, 1'b0, 32'h500, 32'h0, 3'b010, resp_of(32'h500));
    do_req(1'b1, 1'b0, 32'h500, 32'h0, 3'b000, cyc);

    repeat (3) @(negedge clk_in);
    chk("cmd_q_drained", cmd_q.size(), 0);
    chk("resp_q_drained", resp_q.size(), 0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Sequences the single-port memory controller between the instruction cache (fetch) and the load/store buffer (data access). It latches one request at a time, issues it, and tracks it through completion. It returns the result to the requester that owns it. It enforces LSB priority with a starvation bound for fetch, and discards results of requests killed by a pipeline flush. It sits between `inscache`/`lsb` and `memctrl`, replacing their direct connection.

## Interface
- `STARVE_LIMIT`, 4: consecutive LSB grants allowed while a fetch waits (1..15).
- `clk_in` input 1: clock.
- `rst_in` input 1: reset, asynchronous, active-low.
- `rdy_in` input 1: global ready; low freezes all state.
- `clear_in` input 1: pipeline flush.
- `io_buffer_full_in` input 1: UART buffer full; blocks issue.
- `ic_req_in` input 1: fetch request, level, held until `ic_done_out`.
- `ic_addr_in` input 32: fetch address.
- `ic_done_out` output 1: one-cycle fetch completion.
- `ic_data_out` output 32: fetched instruction.
- `lsb_req_in` input 1: data request, level, held until `lsb_done_out`.
- `lsb_store_in` input 1: 1 store, 0 load.
- `lsb_addr_in` input 32: data address.
- `lsb_data_in` input 32: store data.
- `lsb_op_in` input 3: funct3 (width/sign).
- `lsb_done_out` output 1: one-cycle data completion.
- `lsb_data_out` output 32: load result; 0 for stores.
- `mc_fetch_out` output 1: fetch request to controller.
- `mc_io_out` output 1: load/store request to controller.
- `mc_store_out` output 1: store select.
- `mc_addr_out` output 32: access address; carries the fetch address during fetch.
- `mc_fetch_addr_out` output 32: equals `mc_addr_out` at all times.
- `mc_data_out` output 32: store data.
- `mc_op_out` output 3: funct3; forced to 3'b010 during fetch.
- `mc_working_in` input 1: controller busy.
- `mc_ins_done_in` input 1: fetch result valid.
- `mc_ins_in` input 32: fetch result.
- `mc_res_done_in` input 1: load/store done.
- `mc_res_in` input 32: load result.

## Operation
- States: IDLE, ISSUE, WAIT, DRAIN. Owner register: FETCH or DATA. Command fields (`mc_*_out`) are registered and stay stable from ISSUE entry to WAIT exit.
- **IDLE:** if `lsb_req_in` and not starved, grant DATA. Otherwise, if `ic_req_in`, grant FETCH. Load the command and go to ISSUE. If neither is requested, stay.
- **ISSUE:** assert `mc_io_out` or `mc_fetch_out` and hold it until `mc_working_in`=1, then deassert and go to WAIT. While `io_buffer_full_in`=1 the controller does not accept, so the arbiter stays in ISSUE.
- **WAIT:** on `mc_res_done_in` (DATA) or `mc_ins_done_in` (FETCH), register the result, pulse the owner's done for one cycle, and go to IDLE.
- **Flush:** `clear_in` in ISSUE or WAIT with owner FETCH, or with owner DATA and a load, goes to DRAIN. In ISSUE the request has already pulsed, so the command is left in progress. A store in flight is never flushed. `clear_in` in IDLE only suppresses that cycle's grant.
- **DRAIN:** wait for the controller done, drop the result with no done pulse, then go to IDLE.
- **Starvation counter** (3..4 bits): increments on each DATA grant while `ic_req_in`=1. It clears on a FETCH grant or when `ic_req_in`=0. At `STARVE_LIMIT`, FETCH wins the next IDLE decision.
- **Reset values:** state IDLE, all outputs 0, counter 0.

## Timing
- Grant to request visible on `mc_*_out`: 1 cycle (IDLE→ISSUE registered).
- Controller done to requester done: 1 cycle, registered. Done and data are valid in the same cycle.
- Back-to-back requests: the next grant is evaluated in the IDLE cycle after done, so the minimum gap between requests is 1 idle cycle.
- Simultaneous requests in IDLE: LSB wins unless starved.
- A requester may drop `req` only after its done. `req` deasserted mid-flight is ignored; the access completes.
- `clear_in` together with controller done in WAIT: the flush wins, the result is dropped, and the next state is IDLE.
- `rdy_in`=0 holds every register, including the done pulses.
- Asynchronous reset mid-access returns to IDLE immediately. The controller is reset by the same event.

## Configuration
- `MEM_ARB_STARVE_EN` defined: starvation counter and the `STARVE_LIMIT` rule are active.
- `MEM_ARB_STARVE_EN` undefined: fixed LSB priority, no counter logic, and `STARVE_LIMIT` is ignored.

## Structure
- Shared `const.v` gains:
  - state encodings `ARB_IDLE/ARB_ISSUE/ARB_WAIT/ARB_DRAIN` (2-bit);
  - owner codes `ARB_OWN_FETCH/ARB_OWN_DATA`;
  - `FUNCT3_WORD` = 3'b010.
- One sub-module, `arb_starve_cnt`: saturating counter with `limit` output, instantiated only under the macro.

## Test plan
- **Solo fetch:** `ic_req_in`=1, addr 0x100; controller returns 0x00A00093 → one `ic_done_out` with that data; `mc_op_out`=3'b010; `mc_fetch_addr_out`=`mc_addr_out`=0x100.
- **Contention:** LSB load at 0x2000 and fetch at 0x104 raised in the same cycle → load issued first; fetch issued in the IDLE cycle after `lsb_done_out`.
- **Starvation:** with the macro and `STARVE_LIMIT`=4, LSB requests continuously while fetch waits → the 5th grant is FETCH. Without the macro, fetch waits until the LSB drops its request.
- **Flush:**
  - Fetch in WAIT, pulse `clear_in` → no `ic_done_out` for it; the arbiter returns to IDLE only after `mc_ins_done_in`.
  - Store in WAIT, pulse `clear_in` → `lsb_done_out` still pulses.
- **IO backpressure:** `io_buffer_full_in`=1 for 5 cycles with a store to 0x30000 → `mc_io_out` held high for 5 cycles and accepted on the 6th; `rdy_in`=0 mid-WAIT delays done by the same number of cycles.
- **Reset:** assert `rst_in` low in WAIT → all outputs 0 with no clock edge; state IDLE after release.
